// File: rtl/snes_ctrlr_reader_pkg.sv
// Shared types and constants for the dual SNES pad reader: FSM states, CPU
// address map, button bit positions and the CPU read mux.
package snes_ctrlr_reader_pkg;

    localparam int READ_W  = 12;
    localparam int ADDR_W  = 2;
    localparam int FRAME_W = 9;
    localparam int BCNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LO     = 3'd3,
        ST_HI     = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] SNES_ADDR_PAD0 = 2'd0;
    localparam logic [ADDR_W-1:0] SNES_ADDR_PAD1 = 2'd1;
    localparam logic [ADDR_W-1:0] SNES_ADDR_STAT = 2'd2;

    // Bit index of each button inside a pad snapshot (shift-in order)
    typedef enum int unsigned {
        BTN_B      = 0,
        BTN_Y      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7,
        BTN_A      = 8,
        BTN_X      = 9,
        BTN_L      = 10,
        BTN_R      = 11
    } btn_t;

    function automatic logic [READ_W-1:0] read_mux(
        input logic [ADDR_W-1:0]  addr,
        input logic [READ_W-1:0]  pad0,
        input logic [READ_W-1:0]  pad1,
        input logic [FRAME_W-1:0] frame
    );
        logic [READ_W-1:0] r;
        r = '0;
        case (addr)
            SNES_ADDR_PAD0: r = pad0;
            SNES_ADDR_PAD1: r = pad1;
            SNES_ADDR_STAT: r = {{(READ_W-FRAME_W){1'b0}}, frame};
            default:        r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snes_ctrlr_reader_if.sv
// CPU-side read bus of the pad reader: strobe, address and registered read data.
interface snes_ctrlr_reader_if;
    import snes_ctrlr_reader_pkg::*;

    logic                read_enable;
    logic [ADDR_W-1:0]   address;
    logic [READ_W-1:0]   read_data;

    modport master (output read_enable, output address, input  read_data);
    modport slave  (input  read_enable, input  address, output read_data);

endinterface

// File: rtl/snes_ctrlr_reader_phase_timer.sv
// Loadable down-counter timing each scan phase; done is high while the count is zero.
module snes_ctrlr_reader_phase_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/snes_ctrlr_reader.sv
// Polls two SNES pads in parallel on shared latch/clock pins and serves
// 12-bit button snapshots plus a frame counter to the CPU.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for the poll tick
// ST_LATCH  | latch high for LATCH_CYC cycles
// ST_SETTLE | latch low, pulse high; bit 0 sampled on the last cycle
// ST_LO     | pad clock low for HALF_CYC cycles
// ST_HI     | pad clock high; next bit sampled on the last cycle
// ST_COMMIT | one cycle: shift regs copied to holding regs, frame_cnt++
module snes_ctrlr_reader
    import snes_ctrlr_reader_pkg::*;
#(
    parameter int POLL_CYC  = 833334,
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 300,
    parameter int NUM_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    snes_ctrlr_reader_if.slave  bus,
    input  logic [1:0]          snes_data,
    output logic                snes_latch,
    output logic                snes_pulse
);

    localparam int MAX_DUR = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int TW      = (MAX_DUR < 2) ? 1 : $clog2(MAX_DUR);
    localparam int PW      = $clog2(POLL_CYC);

    localparam logic [PW-1:0]     POLL_LAST = PW'(POLL_CYC - 1);
    localparam logic [TW-1:0]     LATCH_LD  = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0]     HALF_LD   = TW'(HALF_CYC - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(NUM_BITS - 1);

    state_t              state_q, state_nx;
    logic [PW-1:0]       poll_cnt;
    logic                tick;
    logic                scan_start;
    logic                sample;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_done;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [1:0]          sync1, sync2;
    logic [READ_W-1:0]   shift0, shift1;
    logic [READ_W-1:0]   hold0, hold1;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                latch_q, pulse_q;
    logic [READ_W-1:0]   read_q;

    assign tick = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    snes_ctrlr_reader_phase_timer #(.W(TW)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        sample     = 1'b0;
        scan_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    scan_start = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = LATCH_LD;
                    state_nx   = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LD;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    sample   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LD;
                    state_nx = ST_LO;
                end
            end
            ST_LO: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LD;
                    state_nx = ST_HI;
                end
            end
            ST_HI: begin
                if (tmr_done) begin
                    sample = 1'b1;
                    if (bit_cnt < LAST_BIT) begin
                        tmr_load = 1'b1;
                        tmr_val  = HALF_LD;
                        state_nx = ST_LO;
                    end else begin
                        state_nx = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Pads idle high, so the synchronizer resets to the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= snes_data;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift0  <= '0;
            shift1  <= '0;
        end else if (scan_start) begin
            bit_cnt <= '0;
            shift0  <= '0;
            shift1  <= '0;
        end else if (sample) begin
            bit_cnt <= bit_cnt + 1'b1;
            for (int k = 0; k < READ_W; k++) begin
                if (bit_cnt == BCNT_W'(k)) begin
                    shift0[k] <= ~sync2[0];
                    shift1[k] <= ~sync2[1];
                end
            end
        end
    end

    // Both pads commit on the same edge so a read never sees a mixed snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold0     <= '0;
            hold1     <= '0;
            frame_cnt <= '0;
        end else if (state_q == ST_COMMIT) begin
            hold0     <= shift0;
            hold1     <= shift1;
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_q <= 1'b0;
            pulse_q <= 1'b1;
            read_q  <= '0;
        end else begin
            latch_q <= (state_nx == ST_LATCH);
            pulse_q <= (state_nx != ST_LO);
            if (bus.read_enable) begin
                read_q <= read_mux(bus.address, hold0, hold1, frame_cnt);
            end else begin
                read_q <= '0;
            end
        end
    end

    assign snes_latch    = latch_q;
    assign snes_pulse    = pulse_q;
    assign bus.read_data = read_q;

endmodule

// File: tb/tb_snes_ctrlr_reader.sv
// Directed bench for snes_ctrlr_reader with behavioural pad models and
// shrunk timing parameters so 512 scans fit in a short run.
module tb_snes_ctrlr_reader;
    import snes_ctrlr_reader_pkg::*;

    localparam int POLL     = 120;
    localparam int LAT      = 4;
    localparam int HALF     = 3;
    localparam int NB       = 16;
    localparam int SCAN_LEN = LAT + 31*HALF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] snes_data;
    logic       snes_latch;
    logic       snes_pulse;

    always #5 clk = ~clk;

    snes_ctrlr_reader_if cpu();

    snes_ctrlr_reader #(
        .POLL_CYC  (POLL),
        .LATCH_CYC (LAT),
        .HALF_CYC  (HALF),
        .NUM_BITS  (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (cpu.slave),
        .snes_data  (snes_data),
        .snes_latch (snes_latch),
        .snes_pulse (snes_pulse)
    );

    // Pad models: word bits are "pressed" flags, wire is active-low
    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    logic [15:0] sh0   = 16'h0000;
    logic [15:0] sh1   = 16'h0000;

    always @(posedge snes_latch or posedge snes_pulse) begin
        if (snes_latch) begin
            sh0 <= word0;
            sh1 <= word1;
        end else begin
            sh0 <= {1'b0, sh0[15:1]};
            sh1 <= {1'b0, sh1[15:1]};
        end
    end

    assign snes_data = {~sh1[0], ~sh0[0]};

    // Pin timing monitor
    int cyc = 0;
    int lat_run = 0, last_lat_w = 0;
    int lo_run = 0, lo_cnt = 0, bad_lo = 0;
    int rise_cyc = 0, rise_prev = 0;
    logic latch_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (snes_latch) lat_run = lat_run + 1;
        else if (lat_run != 0) begin
            last_lat_w = lat_run;
            lat_run = 0;
        end
        if (!snes_pulse) lo_run = lo_run + 1;
        else if (lo_run != 0) begin
            if (lo_run != HALF) bad_lo = bad_lo + 1;
            lo_cnt = lo_cnt + 1;
            lo_run = 0;
        end
        if (snes_latch && !latch_prev) begin
            rise_prev = rise_cyc;
            rise_cyc  = cyc;
        end
        latch_prev = snes_latch;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Called at a negedge; returns at the next negedge
    task automatic do_read(input logic [1:0] a, output logic [11:0] d);
        cpu.read_enable = 1'b1;
        cpu.address     = a;
        @(posedge clk);
        #1;
        d = cpu.read_data;
        cpu.read_enable = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the first negedge after the latch rises
    task automatic wait_latch(output bit ok);
        int n;
        n = 0;
        while (!snes_latch && n < 2*POLL) begin
            @(negedge clk);
            n++;
        end
        ok = snes_latch;
        if (!ok) check("latch_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;

    vec_t        vecs[4];
    logic [11:0] d;
    logic [8:0]  exp_frame;
    logic [11:0] prev0;
    bit          ok;
    int          base_lo, base_bad, n;

    initial begin
        cpu.read_enable = 1'b0;
        cpu.address     = 2'd0;
        vecs[0] = '{w0: 16'h5A5C, w1: 16'hC3F1, e0: 12'hA5C, e1: 12'h3F1};
        vecs[1] = '{w0: 16'hF000, w1: 16'hF000, e0: 12'h000, e1: 12'h000};
        vecs[2] = '{w0: 16'h0FFF, w1: 16'h0001, e0: 12'hFFF, e1: 12'h001};
        vecs[3] = '{w0: 16'h0800, w1: 16'hA123, e0: 12'h800, e1: 12'h123};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_latch", {31'd0, snes_latch}, 32'd0);
        check("reset_pulse", {31'd0, snes_pulse}, 32'd1);
        check("reset_read",  {20'd0, cpu.read_data}, 32'd0);
        exp_frame = 9'd0;

        // Single scans: pattern per pad, discarded trailing bits, all released
        for (int i = 0; i < 4; i++) begin
            word0 = vecs[i].w0;
            word1 = vecs[i].w1;
            wait_latch(ok);
            repeat (SCAN_LEN + 1) @(negedge clk);
            exp_frame = exp_frame + 9'd1;
            do_read(2'd0, d); check($sformatf("vec%0d_pad0", i), {20'd0, d}, {20'd0, vecs[i].e0});
            do_read(2'd1, d); check($sformatf("vec%0d_pad1", i), {20'd0, d}, {20'd0, vecs[i].e1});
            do_read(2'd2, d); check($sformatf("vec%0d_frame", i), {20'd0, d}, {23'd0, exp_frame});
            do_read(2'd3, d); check($sformatf("vec%0d_addr3", i), {20'd0, d}, 32'd0);
        end

        // Pin timing over one scan
        base_lo  = lo_cnt;
        base_bad = bad_lo;
        wait_latch(ok);
        repeat (SCAN_LEN + 1) @(negedge clk);
        exp_frame = exp_frame + 9'd1;
        check("latch_width",  last_lat_w, LAT);
        check("pulse_lows",   lo_cnt - base_lo, NB - 1);
        check("pulse_lo_len", bad_lo - base_bad, 0);
        check("tick_period",  rise_cyc - rise_prev, POLL);

        // Read in the COMMIT cycle, then the next cycle, then with strobe low
        prev0 = vecs[3].e0;
        word0 = 16'hF456;
        wait_latch(ok);
        repeat (SCAN_LEN) @(negedge clk);
        do_read(2'd0, d); check("commit_old", {20'd0, d}, {20'd0, prev0});
        do_read(2'd0, d); check("commit_new", {20'd0, d}, 32'h456);
        @(posedge clk); #1;
        check("read_disabled", {20'd0, cpu.read_data}, 32'd0);
        @(negedge clk);
        exp_frame = exp_frame + 9'd1;
        do_read(2'd2, d); check("commit_frame", {20'd0, d}, {23'd0, exp_frame});

        // Reset asserted while the pad clock is low
        cpu.read_enable = 1'b1;
        cpu.address     = 2'd0;
        n = 0;
        while (snes_pulse && n < 2*POLL) begin
            @(negedge clk);
            n++;
        end
        check("lo_reached", {31'd0, snes_pulse}, 32'd0);
        check("pre_reset_read", {20'd0, cpu.read_data}, 32'h456);
        rst = 1'b0;
        #1;
        check("rst_latch", {31'd0, snes_latch}, 32'd0);
        check("rst_pulse", {31'd0, snes_pulse}, 32'd1);
        check("rst_read",  {20'd0, cpu.read_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pad0", {20'd0, cpu.read_data}, 32'd0);
        @(negedge clk);
        do_read(2'd1, d); check("post_rst_pad1",  {20'd0, d}, 32'd0);
        do_read(2'd2, d); check("post_rst_frame", {20'd0, d}, 32'd0);

        // Frame counter wrap after 512 scans
        word0 = 16'h0ABC;
        word1 = 16'h0DEF;
        for (int s = 1; s <= 512; s++) begin
            wait_latch(ok);
            if (!ok) break;
            repeat (SCAN_LEN + 1) @(negedge clk);
            if (s == 1) begin
                do_read(2'd0, d); check("wrap_pad0", {20'd0, d}, 32'hABC);
                do_read(2'd1, d); check("wrap_pad1", {20'd0, d}, 32'hDEF);
            end
            if (s == 511) begin
                do_read(2'd2, d); check("frame_511", {20'd0, d}, 32'h1FF);
            end
            if (s == 512) begin
                do_read(2'd2, d); check("frame_wrap", {20'd0, d}, 32'd0);
                do_read(2'd3, d); check("wrap_addr3", {20'd0, d}, 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule
